uart_baud_ctrl: RTL and testbench
=================================

// Module: uart_baud_ctrl
// PURPOSE
//  Owns the 2-bit baud-select (B_rate) driving the UART baud-tick generator. Applies CPU-written rates
//  only when TX and RX are idle, so no frame is cut mid-character. Offers an autobaud mode: measures
//  the first low pulse on rx (start bit of 0x55/'U') and selects the nearest of 4800/9600/19200/38400.
//  Sits between the UART register file and the baud generator/TX/RX.
// PARAMETERS
//  SYS_CLK       100000000  system clock frequency, Hz; all thresholds derive from it
//  DEFAULT_RATE  2'b01      b_rate after reset (00=4800 01=9600 10=19200 11=38400)
// PORTS
//  clk          in   1  system clock, rising edge
//  rst_n        in   1  asynchronous, active-low reset
//  wr_en        in   1  1-cycle strobe: request new rate wr_data
//  wr_data      in   2  requested rate code
//  ab_start     in   1  1-cycle strobe: start autobaud measurement
//  tx_busy      in   1  transmitter mid-frame
//  rx_busy      in   1  receiver mid-frame
//  rx_in        in   1  raw asynchronous serial line (idle high)
//  b_rate       out  2  rate code to baud generator (registered)
//  cfg_pending  out  1  manual write waiting for TX/RX idle
//  ab_busy      out  1  autobaud in progress
//  ab_done      out  1  1-cycle pulse: autobaud result applied to b_rate
//  ab_err       out  1  1-cycle pulse: autobaud failed, b_rate unchanged
// BEHAVIOUR
//  Reset: b_rate=DEFAULT_RATE, state IDLE, cfg_pending=ab_busy=ab_done=ab_err=0, counter=0, sync flops=1.
//  rx_in passes a 2-flop synchroniser (rx_s); fall = rx_s_prev & ~rx_s. All decisions use rx_s.
//  Thresholds (clk cycles): T_MIN=SYS_CLK/76800, T_11=SYS_CLK/25600, T_10=SYS_CLK/12800,
//   T_01=SYS_CLK/6400, T_MAX=SYS_CLK/2400. Counter width $clog2(T_MAX)+1, saturates at T_MAX.
//  FSM states: IDLE, PEND, AB_ARM, AB_WAIT, AB_MEAS.
//  IDLE: wr_en & ~tx_busy & ~rx_busy -> b_rate<=wr_data on that edge (visible next cycle), stay IDLE.
//   wr_en with either busy -> latch wr_data as pend_rate, go PEND. ab_start -> AB_ARM.
//   wr_en and ab_start same cycle: wr_en wins, ab_start dropped.
//  PEND: cfg_pending=1. wr_en overwrites pend_rate (last write wins). First cycle with
//   ~tx_busy & ~rx_busy -> b_rate<=pend_rate, go IDLE. ab_start ignored.
//  AB_ARM: ab_busy=1. Wait for rx_s=1 (line idle) -> AB_WAIT.
//  AB_WAIT: ab_busy=1. fall -> clear counter, go AB_MEAS.
//  AB_MEAS: ab_busy=1. counter+1 each cycle rx_s=0. On rx_s=1 with count c:
//   c<T_MIN -> ab_err, glitch; c<T_11 -> 11; c<T_10 -> 10; c<T_01 -> 01; else 00.
//   Valid code: b_rate<=code, ab_done pulse, next IDLE. Error: ab_err pulse, next IDLE.
//   counter reaching T_MAX while low (break) -> ab_err, IDLE.
//  wr_en during AB_* states ignored; tx_busy/rx_busy not consulted during autobaud.
//  ab_done/ab_err assert exactly one cycle, registered, never together.
//  ab_busy/cfg_pending decode from registered state; b_rate changes only at the edges named above.
//  Reset mid-operation: immediate return to reset values, pending write and measurement discarded.
// TESTING (SYS_CLK=100 MHz: T_MIN=1302 T_11=3906 T_10=7812 T_01=15625 T_MAX=41666)
//  1 Reset, idle busies: wr_en wr_data=11 -> b_rate=11 next cycle, cfg_pending never 1.
//  2 tx_busy=1, wr_en 10 then wr_en 00 -> cfg_pending=1, b_rate unchanged; drop tx_busy -> b_rate=00 next
//    cycle, cfg_pending=0.
//  3 ab_start, rx low 10417 cycles then high -> b_rate=01, ab_done one pulse, ab_busy falls with it.
//  4 Autobaud low 2604 -> 11; low 20833 -> 00; low 500 -> ab_err pulse, b_rate unchanged.
//  5 Autobaud, rx held low 50000 cycles -> ab_err at count 41666, IDLE; wr_en during AB_MEAS ignored.
//  6 rst_n low mid AB_MEAS and mid PEND -> b_rate=DEFAULT_RATE, all flags 0, rx rise gives no ab_done.

Source files
------------

// File: rtl/uart_baud_ctrl_if.sv
// Bundle between the UART register file / line side and the baud-select controller.
// The controller uses the slave modport; whatever drives the requests uses master.
interface uart_baud_ctrl_if;
  logic       wr_en;
  logic [1:0] wr_data;
  logic       ab_start;
  logic       tx_busy;
  logic       rx_busy;
  logic       rx_in;
  logic [1:0] b_rate;
  logic       cfg_pending;
  logic       ab_busy;
  logic       ab_done;
  logic       ab_err;

  modport master (
    output wr_en, wr_data, ab_start, tx_busy, rx_busy, rx_in,
    input  b_rate, cfg_pending, ab_busy, ab_done, ab_err
  );

  modport slave (
    input  wr_en, wr_data, ab_start, tx_busy, rx_busy, rx_in,
    output b_rate, cfg_pending, ab_busy, ab_done, ab_err
  );
endinterface

// File: rtl/uart_baud_ctrl.sv
// Baud-select owner: applies CPU rate writes only between frames and measures the start
// bit of a 'U' on rx to pick the nearest of 4800/9600/19200/38400.
//
//  state     | meaning
//  ----------+------------------------------------------------------------
//  S_IDLE    | rate stable; accepts writes and autobaud requests
//  S_PEND    | write held until both TX and RX are idle
//  S_AB_ARM  | autobaud: waiting for the line to be idle (high)
//  S_AB_WAIT | autobaud: waiting for the start-bit falling edge
//  S_AB_MEAS | autobaud: counting the low pulse width
module uart_baud_ctrl #(
  parameter int unsigned SYS_CLK      = 100000000,
  parameter logic [1:0]  DEFAULT_RATE = 2'b01
) (
  input  logic               clk,
  input  logic               rst_n,
  uart_baud_ctrl_if.slave    ctrl_if
);

  localparam int unsigned T_MAX_I = SYS_CLK / 2400;
  localparam int          CNT_W   = $clog2(T_MAX_I) + 1;

  localparam logic [CNT_W-1:0] T_MIN = CNT_W'(SYS_CLK / 76800);
  localparam logic [CNT_W-1:0] T_11  = CNT_W'(SYS_CLK / 25600);
  localparam logic [CNT_W-1:0] T_10  = CNT_W'(SYS_CLK / 12800);
  localparam logic [CNT_W-1:0] T_01  = CNT_W'(SYS_CLK / 6400);
  localparam logic [CNT_W-1:0] T_MAX = CNT_W'(T_MAX_I);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PEND,
    S_AB_ARM,
    S_AB_WAIT,
    S_AB_MEAS
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       b_rate_q, b_rate_d;
  logic [1:0]       pend_rate_q, pend_rate_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ab_done_q, ab_done_d;
  logic             ab_err_q, ab_err_d;
  logic             rx_meta_q, rx_s_q, rx_prev_q;

  logic             both_idle;
  logic             rx_fall;
  logic [1:0]       pend_sel;
  logic [CNT_W-1:0] cnt_inc;

  assign both_idle = ~ctrl_if.tx_busy & ~ctrl_if.rx_busy;
  assign rx_fall   = rx_prev_q & ~rx_s_q;
  assign pend_sel  = ctrl_if.wr_en ? ctrl_if.wr_data : pend_rate_q;
  assign cnt_inc   = cnt_q + 1'b1;

  // Sync flops reset high so a line that is idle at reset never looks like a fall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= ctrl_if.rx_in;
      rx_s_q    <= rx_meta_q;
      rx_prev_q <= rx_s_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      b_rate_q    <= DEFAULT_RATE;
      pend_rate_q <= DEFAULT_RATE;
      cnt_q       <= '0;
      ab_done_q   <= 1'b0;
      ab_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      b_rate_q    <= b_rate_d;
      pend_rate_q <= pend_rate_d;
      cnt_q       <= cnt_d;
      ab_done_q   <= ab_done_d;
      ab_err_q    <= ab_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    b_rate_d    = b_rate_q;
    pend_rate_d = pend_rate_q;
    cnt_d       = cnt_q;
    ab_done_d   = 1'b0;
    ab_err_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (ctrl_if.wr_en) begin
          if (both_idle) begin
            b_rate_d = ctrl_if.wr_data;
          end else begin
            pend_rate_d = ctrl_if.wr_data;
            state_d     = S_PEND;
          end
        end else if (ctrl_if.ab_start) begin
          state_d = S_AB_ARM;
        end
      end

      S_PEND: begin
        pend_rate_d = pend_sel;
        if (both_idle) begin
          b_rate_d = pend_sel;
          state_d  = S_IDLE;
        end
      end

      S_AB_ARM: begin
        if (rx_s_q) state_d = S_AB_WAIT;
      end

      S_AB_WAIT: begin
        if (rx_fall) begin
          cnt_d   = '0;
          state_d = S_AB_MEAS;
        end
      end

      S_AB_MEAS: begin
        if (!rx_s_q) begin
          cnt_d = (cnt_q >= T_MAX) ? T_MAX : cnt_inc;
          // A line stuck low this long is a break, not a start bit.
          if (cnt_inc >= T_MAX) begin
            ab_err_d = 1'b1;
            state_d  = S_IDLE;
          end
        end else begin
          state_d = S_IDLE;
          if (cnt_q < T_MIN) begin
            ab_err_d = 1'b1;
          end else begin
            ab_done_d = 1'b1;
            if (cnt_q < T_11)      b_rate_d = 2'b11;
            else if (cnt_q < T_10) b_rate_d = 2'b10;
            else if (cnt_q < T_01) b_rate_d = 2'b01;
            else                   b_rate_d = 2'b00;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign ctrl_if.b_rate      = b_rate_q;
  assign ctrl_if.cfg_pending = (state_q == S_PEND);
  assign ctrl_if.ab_busy     = (state_q == S_AB_ARM) || (state_q == S_AB_WAIT) ||
                               (state_q == S_AB_MEAS);
  assign ctrl_if.ab_done     = ab_done_q;
  assign ctrl_if.ab_err      = ab_err_q;

endmodule

// File: tb/tb_uart_baud_ctrl.sv
// Directed bench for uart_baud_ctrl with a behavioural reference model compared every cycle.
module tb_uart_baud_ctrl;
  localparam int SYS_CLK = 100000000;
  localparam int T_MIN   = SYS_CLK / 76800;
  localparam int T_11    = SYS_CLK / 25600;
  localparam int T_10    = SYS_CLK / 12800;
  localparam int T_01    = SYS_CLK / 6400;
  localparam int T_MAX   = SYS_CLK / 2400;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  uart_baud_ctrl_if bus();

  uart_baud_ctrl #(.SYS_CLK(SYS_CLK), .DEFAULT_RATE(2'b01)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ctrl_if (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Rate chosen for a low pulse lasting low_cycles clocks on the synchronised line;
  // -1 means rejected. The measured count is one less than the pulse length because
  // the falling-edge cycle itself is where the count starts from zero.
  function automatic int classify(int low_cycles);
    int c;
    c = low_cycles - 1;
    if (c >= T_MAX) return -1;
    if (c < T_MIN)  return -1;
    if (c < T_11)   return 3;
    if (c < T_10)   return 2;
    if (c < T_01)   return 1;
    return 0;
  endfunction

  // Reference model: mode 0 normal, 1 holding a write, 2 autobaud arming,
  // 3 autobaud waiting for a fall, 4 autobaud timing the low pulse.
  logic [1:0] m_rate      = 2'b01;
  logic [1:0] m_pend_rate = 2'b01;
  int         m_mode      = 0;
  int         m_low       = 0;
  bit         m_done      = 1'b0;
  bit         m_err       = 1'b0;
  bit         r1 = 1'b1, r2 = 1'b1, r2p = 1'b1;
  bit         line, fell;
  int         code;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_rate = 2'b01; m_pend_rate = 2'b01; m_mode = 0; m_low = 0;
      m_done = 1'b0;  m_err = 1'b0; r1 = 1'b1; r2 = 1'b1; r2p = 1'b1;
    end else begin
      line   = r2;
      fell   = r2p & ~r2;
      m_done = 1'b0;
      m_err  = 1'b0;
      case (m_mode)
        0: begin
          if (bus.wr_en) begin
            if (!bus.tx_busy && !bus.rx_busy) m_rate = bus.wr_data;
            else begin m_pend_rate = bus.wr_data; m_mode = 1; end
          end else if (bus.ab_start) m_mode = 2;
        end
        1: begin
          if (bus.wr_en) m_pend_rate = bus.wr_data;
          if (!bus.tx_busy && !bus.rx_busy) begin m_rate = m_pend_rate; m_mode = 0; end
        end
        2: if (line) m_mode = 3;
        3: if (fell) begin m_low = 1; m_mode = 4; end
        4: begin
          if (!line) begin
            m_low++;
            if (m_low - 1 >= T_MAX) begin m_err = 1'b1; m_mode = 0; end
          end else begin
            code = classify(m_low);
            if (code < 0) m_err = 1'b1;
            else begin m_rate = code[1:0]; m_done = 1'b1; end
            m_mode = 0;
          end
        end
        default: m_mode = 0;
      endcase
      r2p = r2; r2 = r1; r1 = bus.rx_in;
    end
  end

  always @(negedge clk) begin
    checks++;
    if ({bus.b_rate, bus.cfg_pending, bus.ab_busy, bus.ab_done, bus.ab_err} !==
        {m_rate, m_mode == 1, m_mode >= 2, m_done, m_err}) begin
      errors++;
      $display("FAIL cycle_outputs t=%0t actual rate/pend/busy/done/err=%b required=%b", $time,
               {bus.b_rate, bus.cfg_pending, bus.ab_busy, bus.ab_done, bus.ab_err},
               {m_rate, m_mode == 1, m_mode >= 2, m_done, m_err});
    end
  end

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic cyc(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Start autobaud, drive a low pulse of low_len cycles, then wait (bounded) for the result.
  task automatic autobaud(string name, int low_len, bit exp_done, int exp_rate);
    bit seen;
    bus.ab_start = 1'b1; cyc(1); bus.ab_start = 1'b0;
    cyc(4);
    bus.rx_in = 1'b0; cyc(low_len); bus.rx_in = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cyc(1);
      if (bus.ab_done || bus.ab_err) begin seen = 1'b1; break; end
    end
    chk({name, "_result_seen"}, int'(seen), 1);
    chk({name, "_done"}, int'(bus.ab_done), int'(exp_done));
    chk({name, "_err"}, int'(bus.ab_err), int'(!exp_done));
    chk({name, "_busy_fell"}, int'(bus.ab_busy), 0);
    chk({name, "_rate"}, int'(bus.b_rate), exp_rate);
    cyc(1);
    chk({name, "_one_pulse"}, int'(bus.ab_done | bus.ab_err), 0);
  endtask

  initial begin
    bus.wr_en = 1'b0; bus.wr_data = 2'b00; bus.ab_start = 1'b0;
    bus.tx_busy = 1'b0; bus.rx_busy = 1'b0; bus.rx_in = 1'b1;

    chk("pin_10417", classify(10417), 1);
    chk("pin_2604", classify(2604), 3);
    chk("pin_20833", classify(20833), 0);
    chk("pin_500", classify(500), -1);
    chk("pin_1303", classify(1303), 3);
    chk("pin_1302", classify(1302), -1);

    cyc(3);
    chk("reset_rate", int'(bus.b_rate), 1);
    chk("reset_flags", int'({bus.cfg_pending, bus.ab_busy, bus.ab_done, bus.ab_err}), 0);
    rst_n = 1'b1;
    cyc(2);

    // Direct write while idle
    bus.wr_en = 1'b1; bus.wr_data = 2'b11; cyc(1); bus.wr_en = 1'b0;
    chk("t1_rate", int'(bus.b_rate), 3);
    chk("t1_pending", int'(bus.cfg_pending), 0);
    cyc(2);

    // Deferred writes, last one wins
    bus.tx_busy = 1'b1;
    bus.wr_en = 1'b1; bus.wr_data = 2'b10; cyc(1); bus.wr_en = 1'b0;
    chk("t2_pending", int'(bus.cfg_pending), 1);
    cyc(2);
    bus.wr_en = 1'b1; bus.wr_data = 2'b00; bus.ab_start = 1'b1; cyc(1);
    bus.wr_en = 1'b0; bus.ab_start = 1'b0;
    cyc(2);
    chk("t2_held_rate", int'(bus.b_rate), 3);
    chk("t2_no_ab", int'(bus.ab_busy), 0);
    bus.tx_busy = 1'b0; cyc(1);
    chk("t2_applied", int'(bus.b_rate), 0);
    chk("t2_pending_clr", int'(bus.cfg_pending), 0);
    cyc(2);

    // wr_en beats ab_start in the same cycle
    bus.wr_en = 1'b1; bus.wr_data = 2'b10; bus.ab_start = 1'b1; cyc(1);
    bus.wr_en = 1'b0; bus.ab_start = 1'b0;
    chk("both_rate", int'(bus.b_rate), 2);
    chk("both_no_ab", int'(bus.ab_busy), 0);
    cyc(2);

    autobaud("ab10417", 10417, 1'b1, 1);
    autobaud("ab2604", 2604, 1'b1, 3);
    autobaud("ab20833", 20833, 1'b1, 0);
    autobaud("ab500", 500, 1'b0, 0);
    autobaud("ab1302", 1302, 1'b0, 0);
    autobaud("ab1303", 1303, 1'b1, 3);

    // Break: line held low past the longest bit time; write during measurement ignored
    begin
      bit seen;
      bus.ab_start = 1'b1; cyc(1); bus.ab_start = 1'b0;
      cyc(4);
      bus.rx_in = 1'b0; cyc(100);
      bus.wr_en = 1'b1; bus.wr_data = 2'b01; cyc(1); bus.wr_en = 1'b0;
      chk("brk_wr_ignored", int'(bus.b_rate), 3);
      cyc(41500);
      seen = 1'b0;
      for (int i = 0; i < 200; i++) begin
        cyc(1);
        if (bus.ab_err || bus.ab_done) begin seen = 1'b1; break; end
      end
      chk("brk_seen", int'(seen), 1);
      chk("brk_err", int'(bus.ab_err), 1);
      chk("brk_done", int'(bus.ab_done), 0);
      chk("brk_rate", int'(bus.b_rate), 3);
      cyc(1200);
      bus.rx_in = 1'b1; cyc(10);
      chk("brk_idle", int'(bus.ab_busy), 0);
    end

    // Reset during measurement
    bus.ab_start = 1'b1; cyc(1); bus.ab_start = 1'b0;
    cyc(4);
    bus.rx_in = 1'b0; cyc(1000);
    rst_n = 1'b0; cyc(2);
    chk("rst_meas_rate", int'(bus.b_rate), 1);
    chk("rst_meas_flags", int'({bus.cfg_pending, bus.ab_busy, bus.ab_done, bus.ab_err}), 0);
    rst_n = 1'b1; bus.rx_in = 1'b1; cyc(10);
    chk("rst_meas_no_done", int'(bus.ab_done | bus.ab_busy), 0);

    // Reset during a held write
    bus.tx_busy = 1'b1;
    bus.wr_en = 1'b1; bus.wr_data = 2'b10; cyc(1); bus.wr_en = 1'b0;
    chk("rst_pend_set", int'(bus.cfg_pending), 1);
    rst_n = 1'b0; cyc(1);
    chk("rst_pend_clr", int'(bus.cfg_pending), 0);
    rst_n = 1'b1; bus.tx_busy = 1'b0; cyc(3);
    chk("rst_pend_discard", int'(bus.b_rate), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
